// File: rtl/logicnet_lut_neuron_rt_if.sv
// Lookup/config bundle for the runtime-programmable LUT neuron.
//   cfg_we/cfg_addr/cfg_data/cfg_clear : table programming from the controller
//   in_valid/in_ready/in_data          : lookup request (address = fan-in activations)
//   out_valid/out_ready/out_data       : registered looked-up activation
// master = upstream controller/fan-in side, slave = the neuron.
interface logicnet_lut_neuron_rt_if #(
    parameter int unsigned IN_BITS  = 6,
    parameter int unsigned OUT_BITS = 2
);
    logic                cfg_we;
    logic [IN_BITS-1:0]  cfg_addr;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_clear;
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_clear,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_clear,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/logicnet_lut_neuron_rt.sv
// Runtime-programmable registered LUT neuron.
// Holds a 2^IN_BITS-entry truth table in distributed RAM, swept to zero after
// reset or on cfg_clear, and serves lookups through a valid/ready handshake
// with one registered output stage.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : slave side of logicnet_lut_neuron_rt_if (cfg, lookup, result)
//   busy       : high while the clear sweep is running
//   lookup_cnt : accepted lookups since reset/clear, saturating
module logicnet_lut_neuron_rt #(
    parameter int unsigned IN_BITS  = 6,
    parameter int unsigned OUT_BITS = 2,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    logicnet_lut_neuron_rt_if.slave   bus,
    output logic                      busy,
    output logic [CNT_BITS-1:0]       lookup_cnt
);

    localparam int unsigned          DEPTH     = 2 ** IN_BITS;
    localparam logic [IN_BITS-1:0]   LAST_ADDR = IN_BITS'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IN_BITS-1:0]   clr_addr_q, clr_addr_d;
    logic                 enter_clear_c;
    logic                 accept_c;

    logic [OUT_BITS-1:0]  lut_mem [DEPTH];
    logic                 out_valid_q;
    logic [OUT_BITS-1:0]  out_data_q;
    logic [CNT_BITS-1:0]  lookup_cnt_q;

    // State and sweep-address register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state: sweep every entry once, then serve until cfg_clear
    always_comb begin
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        enter_clear_c = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + IN_BITS'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = RUN;
                    clr_addr_d = '0;
                end
            end
            RUN: begin
                if (bus.cfg_clear) begin
                    state_d       = CLEAR;
                    enter_clear_c = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign busy         = (state_q == CLEAR);
    assign bus.in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Table write port: the sweep owns it in CLEAR, cfg writes are dropped there.
    // No reset on the array; the sweep that follows reset zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                lut_mem[clr_addr_q] <= '0;
            end else if (bus.cfg_we) begin
                lut_mem[bus.cfg_addr] <= bus.cfg_data;
            end
        end
    end

    // Output stage; reading lut_mem here sees the pre-write entry on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= lut_mem[bus.in_data];
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Saturating lookup counter, zeroed when a clear is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_cnt_q <= '0;
        end else if (enter_clear_c) begin
            lookup_cnt_q <= '0;
        end else if (accept_c && (lookup_cnt_q != CNT_MAX)) begin
            lookup_cnt_q <= lookup_cnt_q + CNT_BITS'(1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign lookup_cnt    = lookup_cnt_q;

endmodule

// File: tb/tb_logicnet_lut_neuron_rt.sv
// Self-checking bench for logicnet_lut_neuron_rt (IN_BITS=6, OUT_BITS=2, CNT_BITS=4).
module tb_logicnet_lut_neuron_rt;

    localparam int IN_BITS  = 6;
    localparam int OUT_BITS = 2;
    localparam int CNT_BITS = 4;
    localparam int DEPTH    = 64;
    localparam int CMAX     = 15;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic [CNT_BITS-1:0] lookup_cnt;

    logicnet_lut_neuron_rt_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

    logicnet_lut_neuron_rt #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .lookup_cnt(lookup_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: table contents, mode, pending output word, counter
    logic [1:0] m_mem [DEPTH];
    bit         m_run;
    int         m_left;
    logic       m_ov;
    logic [1:0] m_od;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_left = DEPTH;
        m_ov   = 1'b0;
        m_od   = 2'b00;
        m_cnt  = 0;
        foreach (m_mem[i]) m_mem[i] = 2'b00;
    endtask

    // One clock cycle: drive at negedge, check handshake, model the edge, check outputs
    task automatic cycle(input string tag, input logic r, input logic we,
                         input logic [5:0] a, input logic [1:0] d, input logic clr,
                         input logic iv, input logic [5:0] id, input logic ordy);
        logic exp_rdy;
        logic acc;
        rst           = r;
        bus.cfg_we    = we;
        bus.cfg_addr  = a;
        bus.cfg_data  = d;
        bus.cfg_clear = clr;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        exp_rdy = m_run && (!m_ov || ordy);
        chk({tag, ":busy"}, 32'(busy), 32'(!m_run));
        chk({tag, ":in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
        acc = iv && exp_rdy;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (acc) begin
                m_od = m_mem[id];
                m_ov = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            if (m_run) begin
                if (we) m_mem[a] = d;
                if (clr) begin
                    // table is unreadable until the sweep ends, so zero it at once
                    m_run  = 1'b0;
                    m_left = DEPTH;
                    m_cnt  = 0;
                    foreach (m_mem[i]) m_mem[i] = 2'b00;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_run = 1'b1;
            end
        end
        @(negedge clk);
        chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(m_ov));
        chk({tag, ":out_data"}, 32'(bus.out_data), 32'(m_od));
        chk({tag, ":lookup_cnt"}, 32'(lookup_cnt), 32'(m_cnt));
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic look(input string tag, input logic [5:0] id, input logic ordy);
        cycle(tag, 0, 0, 0, 0, 0, 1, id, ordy);
    endtask

    task automatic wr(input string tag, input logic [5:0] a, input logic [1:0] d);
        cycle(tag, 0, 1, a, d, 0, 0, 0, 1);
    endtask

    // Runs cycles with random noise inputs while busy, returns the number of busy cycles
    task automatic run_clear(input string tag, input int ordy_after, output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            cycle(tag, 0, 1'($urandom_range(0, 1)), 6'($urandom), 2'($urandom),
                  1'($urandom_range(0, 1)), 1'b1, 6'($urandom), 1'(n >= ordy_after));
            n++;
        end
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.cfg_clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles, then the post-reset sweep
        cycle("rst", 1, 0, 0, 0, 0, 1, 0, 1);
        cycle("rst", 1, 0, 0, 0, 0, 1, 0, 1);
        run_clear("sweep0", 0, n);
        chk("sweep0_len", 32'(n), 32'd64);
        look("zero_lk", 6'd0, 1);
        look("zero_lk", 6'd21, 1);
        look("zero_lk", 6'd63, 1);
        chk("zero_lk63", 32'(bus.out_data), 32'd0);
        idle("zero_idle", 1);
        chk("zero_cnt", 32'(lookup_cnt), 32'd3);

        // Program two entries, back-to-back lookups
        wr("prog", 6'b101101, 2'b11);
        wr("prog", 6'b000001, 2'b10);
        look("b2b", 6'd45, 1);
        chk("b2b_45", 32'(bus.out_data), 32'h3);
        look("b2b", 6'd1, 1);
        chk("b2b_1", 32'(bus.out_data), 32'h2);
        look("b2b", 6'd0, 1);
        chk("b2b_0", 32'(bus.out_data), 32'h0);
        idle("b2b_idle", 1);

        // Backpressure: one word taken, rest stalled, then released
        for (int i = 0; i < 5; i++) cycle("bp", 0, 0, 0, 0, 0, 1, (i == 0) ? 6'd45 : 6'd1, 0);
        chk("bp_held", 32'(bus.out_data), 32'h3);
        look("bp_rel", 6'd1, 1);
        chk("bp_next", 32'(bus.out_data), 32'h2);
        idle("bp_idle", 2);

        // Read-before-write collision
        wr("coll", 6'd7, 2'b01);
        cycle("coll", 0, 1, 6'd7, 2'b10, 0, 1, 6'd7, 1);
        chk("coll_old", 32'(bus.out_data), 32'h1);
        look("coll", 6'd7, 1);
        chk("coll_new", 32'(bus.out_data), 32'h2);
        idle("coll_idle", 1);

        // cfg_clear with a pending word, noisy cfg during the sweep
        look("clr_pend", 6'd45, 0);
        cycle("clr_req", 0, 1, 6'd9, 2'b11, 1, 0, 0, 0);
        chk("clr_pend_word", 32'(bus.out_data), 32'h3);
        chk("clr_cnt0", 32'(lookup_cnt), 32'd0);
        run_clear("sweep1", 3, n);
        chk("sweep1_len", 32'(n), 32'd64);
        chk("sweep1_cnt", 32'(lookup_cnt), 32'd0);
        for (int i = 0; i < DEPTH; i++) look("clr_read", 6'(i), 1);
        idle("clr_idle", 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle("rand", 1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) == 0),
                  6'($urandom), 2'($urandom), 1'($urandom_range(0, 149) == 0),
                  1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Saturation after a fresh clear
        n = 0;
        while (!m_run && n < 100) begin
            idle("wait_run", 1);
            n++;
        end
        cycle("sat_clr", 0, 0, 0, 0, 1, 0, 0, 1);
        run_clear("sweep2", 0, n);
        for (int i = 0; i < 20; i++) look("sat", 6'($urandom), 1);
        chk("sat_cnt", 32'(lookup_cnt), 32'd15);

        // Reset pulse mid-sweep restarts a full sweep
        cycle("mid_clr", 0, 0, 0, 0, 1, 1, 6'd2, 0);
        idle("mid", 30);
        cycle("mid_rst", 1, 0, 0, 0, 0, 1, 0, 1);
        chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
        run_clear("sweep3", 0, n);
        chk("sweep3_len", 32'(n), 32'd64);
        look("post", 6'd45, 1);
        chk("post_zero", 32'(bus.out_data), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
